// File: rtl/mem_stage_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_dmem_ctrl
// Description : MEM pipeline stage. Owns the data memory and models a
//               configurable multi-cycle access latency with a small
//               IDLE/BUSY/DONE FSM. STALL freezes the upstream pipeline while
//               an access is in flight. Writeback is bubbled while stalled.
// Optional    : DMEM_ALIGN_CHK_EN - when defined, word-misaligned accesses
//               are suppressed and flagged on MISALIGN.
// Ports       : CLK, RESET_N (async, active-low)
//               WB_EN_IN, MEM_READ_EN_IN, MEM_WRITE_EN_IN  - EX/MEM controls
//               ALU_RESULT_IN, ST_VAL_IN, DESTINATION_IN   - EX/MEM data
//               WB_EN_OUT, MEM_READ_EN_OUT, ALU_RESULT_OUT,
//               MEM_READ_OPERAND_OUT, DESTINATION_OUT      - to MEM/WB
//               STALL, MISALIGN                            - to hazard unit
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef REG_ADDR_LEN
`define REG_ADDR_LEN 5
`endif

module mem_stage_dmem_ctrl #(
    parameter int DMEM_DEPTH = 1024,
    parameter int ACCESS_LAT = 2
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     WB_EN_IN,
    input  logic                     MEM_READ_EN_IN,
    input  logic                     MEM_WRITE_EN_IN,
    input  logic [`WORD_LEN-1:0]     ALU_RESULT_IN,
    input  logic [`WORD_LEN-1:0]     ST_VAL_IN,
    input  logic [`REG_ADDR_LEN-1:0] DESTINATION_IN,
    output logic                     WB_EN_OUT,
    output logic                     MEM_READ_EN_OUT,
    output logic [`WORD_LEN-1:0]     ALU_RESULT_OUT,
    output logic [`WORD_LEN-1:0]     MEM_READ_OPERAND_OUT,
    output logic [`REG_ADDR_LEN-1:0] DESTINATION_OUT,
    output logic                     STALL,
    output logic                     MISALIGN
);

    localparam int c_IDX_W = $clog2(DMEM_DEPTH);
    // Counter holds the number of stall cycles still to come after the
    // current one, so it never exceeds ACCESS_LAT-1.
    localparam int c_CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD =
        c_CNT_W'((ACCESS_LAT > 0) ? (ACCESS_LAT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [`WORD_LEN-1:0] r_mem [DMEM_DEPTH];

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [`WORD_LEN-1:0] r_rd_q;
    logic [`WORD_LEN-1:0] w_rd_data;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_acc;
    logic                 w_is_load;
    logic                 w_misalign;
    logic                 w_go;
    logic                 w_capture;
    logic                 w_stall_raw;
    logic                 w_mem_we;
    logic                 w_unused;

    // Upper address bits wrap the word index modulo DMEM_DEPTH.
    assign w_idx     = ALU_RESULT_IN[c_IDX_W+1:2];
    assign w_acc     = MEM_READ_EN_IN | MEM_WRITE_EN_IN;
    // Read+write together behaves as a store; no load data is returned.
    assign w_is_load = MEM_READ_EN_IN & ~MEM_WRITE_EN_IN;
    assign w_unused  = ^{ALU_RESULT_IN[`WORD_LEN-1:c_IDX_W+2], ALU_RESULT_IN[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
    assign w_misalign = w_acc & (ALU_RESULT_IN[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_go = w_acc & ~w_misalign;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rd_q  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_rd_q <= r_mem[w_idx];
            end
        end
    end

    // Memory contents are deliberately not reset. A store only commits on the
    // edge leaving DONE, so a reset during IDLE/BUSY discards it.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= ST_VAL_IN;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_stall_raw = 1'b0;
        w_mem_we    = 1'b0;
        w_rd_data   = '0;
        if (ACCESS_LAT == 0) begin
            // Single-cycle memory: combinational read, write on the edge.
            w_state_nxt = S_IDLE;
            w_mem_we    = w_go & MEM_WRITE_EN_IN;
            if (w_go && w_is_load) begin
                w_rd_data = r_mem[w_idx];
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        w_stall_raw = 1'b1;
                        w_cnt_nxt   = c_CNT_LOAD;
                        if (ACCESS_LAT > 1) begin
                            w_state_nxt = S_BUSY;
                        end else begin
                            w_state_nxt = S_DONE;
                            w_capture   = 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    w_stall_raw = 1'b1;
                    w_cnt_nxt   = r_cnt - 1'b1;
                    if (w_cnt_nxt == '0) begin
                        w_state_nxt = S_DONE;
                        w_capture   = 1'b1;
                    end
                end
                S_DONE: begin
                    // Always return through IDLE so a following op restarts
                    // its own latency count.
                    w_state_nxt = S_IDLE;
                    w_mem_we    = MEM_WRITE_EN_IN;
                    if (w_is_load) begin
                        w_rd_data = r_rd_q;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // STALL is forced low while reset is held so the pipeline is released
    // immediately, even if EX/MEM still presents an access.
    assign STALL                = w_stall_raw & RESET_N;
    assign WB_EN_OUT            = WB_EN_IN & ~STALL & ~w_misalign;
    assign MEM_READ_EN_OUT      = MEM_READ_EN_IN & ~STALL;
    assign ALU_RESULT_OUT       = ALU_RESULT_IN;
    assign DESTINATION_OUT      = DESTINATION_IN;
    assign MEM_READ_OPERAND_OUT = w_rd_data;
    assign MISALIGN             = w_misalign;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_dmem_ctrl
// Description : Self-checking bench for mem_stage_dmem_ctrl. A reference model
//               derives every output from the op being presented and how many
//               cycles it has been held; a compare process checks each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_dmem_ctrl;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        WB_EN_IN;
    logic        MEM_READ_EN_IN;
    logic        MEM_WRITE_EN_IN;
    logic [31:0] ALU_RESULT_IN;
    logic [31:0] ST_VAL_IN;
    logic [4:0]  DESTINATION_IN;
    logic        WB_EN_OUT;
    logic        MEM_READ_EN_OUT;
    logic [31:0] ALU_RESULT_OUT;
    logic [31:0] MEM_READ_OPERAND_OUT;
    logic [4:0]  DESTINATION_OUT;
    logic        STALL;
    logic        MISALIGN;

    always #5 CLK = ~CLK;

    mem_stage_dmem_ctrl #(
        .DMEM_DEPTH(DEPTH),
        .ACCESS_LAT(LAT)
    ) dut (
        .CLK                 (CLK),
        .RESET_N             (RESET_N),
        .WB_EN_IN            (WB_EN_IN),
        .MEM_READ_EN_IN      (MEM_READ_EN_IN),
        .MEM_WRITE_EN_IN     (MEM_WRITE_EN_IN),
        .ALU_RESULT_IN       (ALU_RESULT_IN),
        .ST_VAL_IN           (ST_VAL_IN),
        .DESTINATION_IN      (DESTINATION_IN),
        .WB_EN_OUT           (WB_EN_OUT),
        .MEM_READ_EN_OUT     (MEM_READ_EN_OUT),
        .ALU_RESULT_OUT      (ALU_RESULT_OUT),
        .MEM_READ_OPERAND_OUT(MEM_READ_OPERAND_OUT),
        .DESTINATION_OUT     (DESTINATION_OUT),
        .STALL               (STALL),
        .MISALIGN            (MISALIGN)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Op tracking shared between the driver and the compare process.
    logic        chk_en = 1'b0;
    int          cur_k  = 0;
    int          cur_n  = 1;
    int          op_stall_cnt = 0;
    logic [31:0] op_done_operand;
    logic        op_done_wb;
    logic        op_done_mis;

    // Reference memory: word-addressed, address wraps modulo DEPTH.
    logic [31:0] model_mem [DEPTH];
    bit          model_vld [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int word_idx(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    function automatic logic is_misaligned(input logic rd, input logic wr, input logic [31:0] addr);
`ifdef DMEM_ALIGN_CHK_EN
        return (rd | wr) && (addr % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Every memory op spends LAT stall cycles then one completion cycle.
    always @(negedge CLK) begin : cmp
        logic acc, mis, e_stall, e_wb, e_rden, ld;
        int   idx;
        if (chk_en) begin
            acc     = MEM_READ_EN_IN | MEM_WRITE_EN_IN;
            mis     = is_misaligned(MEM_READ_EN_IN, MEM_WRITE_EN_IN, ALU_RESULT_IN);
            e_stall = acc && !mis && (cur_k < LAT);
            e_wb    = WB_EN_IN && !e_stall && !mis;
            e_rden  = MEM_READ_EN_IN && !e_stall;
            ld      = MEM_READ_EN_IN && !MEM_WRITE_EN_IN && !mis && (cur_k == LAT);
            idx     = word_idx(ALU_RESULT_IN);
            check("stall",    {31'b0, STALL},           {31'b0, e_stall});
            check("wb_en",    {31'b0, WB_EN_OUT},       {31'b0, e_wb});
            check("rd_en",    {31'b0, MEM_READ_EN_OUT}, {31'b0, e_rden});
            check("misalign", {31'b0, MISALIGN},        {31'b0, mis});
            check("alu_pass", ALU_RESULT_OUT,           ALU_RESULT_IN);
            check("dest_pass", {27'b0, DESTINATION_OUT}, {27'b0, DESTINATION_IN});
            if (!ld) begin
                check("operand_zero", MEM_READ_OPERAND_OUT, 32'h0);
            end else if (model_vld[idx]) begin
                check("operand_load", MEM_READ_OPERAND_OUT, model_mem[idx]);
            end
            if (STALL === 1'b1) op_stall_cnt++;
            if (cur_k == cur_n - 1) begin
                op_done_operand = MEM_READ_OPERAND_OUT;
                op_done_wb      = WB_EN_OUT;
                op_done_mis     = MISALIGN;
            end
        end
    end

    task automatic run_op(input logic rd, input logic wr, input logic wb,
                          input logic [31:0] addr, input logic [31:0] val,
                          input logic [4:0] dest);
        logic mis;
        MEM_READ_EN_IN  = rd;
        MEM_WRITE_EN_IN = wr;
        WB_EN_IN        = wb;
        ALU_RESULT_IN   = addr;
        ST_VAL_IN       = val;
        DESTINATION_IN  = dest;
        mis             = is_misaligned(rd, wr, addr);
        cur_n           = ((rd | wr) && !mis) ? LAT + 1 : 1;
        op_stall_cnt    = 0;
        for (int k = 0; k < cur_n; k++) begin
            cur_k  = k;
            chk_en = 1'b1;
            @(posedge CLK);
            #1;
        end
        chk_en = 1'b0;
        if (wr && !mis) begin
            model_mem[word_idx(addr)] = val;
            model_vld[word_idx(addr)] = 1'b1;
        end
    endtask

    task automatic drive_nop();
        MEM_READ_EN_IN  = 1'b0;
        MEM_WRITE_EN_IN = 1'b0;
        WB_EN_IN        = 1'b0;
        ALU_RESULT_IN   = 32'h0;
        ST_VAL_IN       = 32'h0;
        DESTINATION_IN  = 5'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model_vld[i] = 1'b0;

        // Reset with a load already presented: STALL must stay low.
        RESET_N         = 1'b1;
        MEM_READ_EN_IN  = 1'b1;
        MEM_WRITE_EN_IN = 1'b0;
        WB_EN_IN        = 1'b1;
        ALU_RESULT_IN   = 32'h10;
        ST_VAL_IN       = 32'h0;
        DESTINATION_IN  = 5'd1;
        #1 RESET_N = 1'b0;
        #2;
        check("rst_stall",    {31'b0, STALL},    32'h0);
        check("rst_operand",  MEM_READ_OPERAND_OUT, 32'h0);
        check("rst_misalign", {31'b0, MISALIGN}, 32'h0);
        @(posedge CLK); @(posedge CLK); #1;
        check("rst_stall_hold", {31'b0, STALL}, 32'h0);
        drive_nop();
        #1 RESET_N = 1'b1;

        // Store 0xDEADBEEF to 0x10: two stall cycles.
        run_op(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
        check("st10_stalls", op_stall_cnt, 32'd2);

        // Non-memory op: no stall, passthrough same cycle.
        run_op(1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 5'd7);
        check("alu_stalls", op_stall_cnt, 32'd0);
        check("alu_wb",     {31'b0, op_done_wb}, 32'h1);

        // Load from 0x10 returns the stored word in its completion cycle.
        run_op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd3);
        check("ld10_value",  op_done_operand, 32'hDEADBEEF);
        check("ld10_wb",     {31'b0, op_done_wb}, 32'h1);
        check("ld10_stalls", op_stall_cnt, 32'd2);

        // Seed 0x20 for the reset-during-store case.
        run_op(1'b0, 1'b1, 1'b0, 32'h20, 32'h0BADF00D, 5'd0);

        // Back-to-back load then store.
        run_op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd4);
        check("b2b_ld_stalls", op_stall_cnt, 32'd2);
        run_op(1'b0, 1'b1, 1'b0, 32'h14, 32'hCAFEF00D, 5'd0);
        check("b2b_st_stalls", op_stall_cnt, 32'd2);
        run_op(1'b1, 1'b0, 1'b1, 32'h14, 32'h0, 5'd5);
        check("ld14_value", op_done_operand, 32'hCAFEF00D);

        // Address wrap: 0x1004 and 0x0004 hit the same word.
        run_op(1'b0, 1'b1, 1'b0, 32'h1004, 32'h1234, 5'd0);
        run_op(1'b1, 1'b0, 1'b1, 32'h0004, 32'h0, 5'd6);
        check("wrap_value", op_done_operand, 32'h1234);

        // Read+write together: acts as a store, operand 0.
        run_op(1'b1, 1'b1, 1'b1, 32'h18, 32'h77, 5'd2);
        check("rw_operand", op_done_operand, 32'h0);
        run_op(1'b1, 1'b0, 1'b1, 32'h18, 32'h0, 5'd2);
        check("rw_stored", op_done_operand, 32'h77);

        // Reset while a store to 0x20 is in BUSY.
        MEM_READ_EN_IN  = 1'b0;
        MEM_WRITE_EN_IN = 1'b1;
        WB_EN_IN        = 1'b0;
        ALU_RESULT_IN   = 32'h20;
        ST_VAL_IN       = 32'h11111111;
        DESTINATION_IN  = 5'd0;
        @(posedge CLK); #1;
        check("busy_stall", {31'b0, STALL}, 32'h1);
        #2 RESET_N = 1'b0;
        #1;
        check("async_drop_stall", {31'b0, STALL}, 32'h0);
        drive_nop();
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        run_op(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd8);
        check("ld20_old", op_done_operand, 32'h0BADF00D);

`ifdef DMEM_ALIGN_CHK_EN
        // Misaligned load is suppressed.
        run_op(1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 5'd9);
        check("mis_flag",    {31'b0, op_done_mis}, 32'h1);
        check("mis_stalls",  op_stall_cnt, 32'd0);
        check("mis_wb",      {31'b0, op_done_wb}, 32'h0);
        check("mis_operand", op_done_operand, 32'h0);
`else
        // Low address bits are ignored: 0x13 reads the word at 0x10.
        run_op(1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 5'd9);
        check("lowbits_value", op_done_operand, 32'hDEADBEEF);
        check("lowbits_mis",   {31'b0, op_done_mis}, 32'h0);
`endif

        run_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage_dmem_ctrl.md
Name: mem_stage_dmem_ctrl

Overview:
- MEM pipeline stage, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Owns the data memory array and models a configurable multi-cycle access latency.
- Runs a small FSM that raises STALL to the hazard unit while an access is in flight.
- Presents ALU result, read operand and writeback controls to MEM/WB.
- Inserts a writeback bubble while stalled.

Parameters:
- DMEM_DEPTH, 1024: number of `WORD_LEN-bit words in the data memory; power of two.
- ACCESS_LAT, 2: stall cycles per load/store; 0 means a single-cycle access with no stall.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- WB_EN_IN  in  1  writeback enable from EX/MEM.
- MEM_READ_EN_IN  in  1  load request from EX/MEM.
- MEM_WRITE_EN_IN  in  1  store request from EX/MEM.
- ALU_RESULT_IN  in  `WORD_LEN  byte address, or ALU result for non-memory ops.
- ST_VAL_IN  in  `WORD_LEN  store data.
- DESTINATION_IN  in  `REG_ADDR_LEN  destination register.
- WB_EN_OUT  out  1  writeback enable to MEM/WB; forced 0 while STALL=1.
- MEM_READ_EN_OUT  out  1  MEM_READ_EN_IN gated by ~STALL.
- ALU_RESULT_OUT  out  `WORD_LEN  ALU_RESULT_IN passthrough.
- MEM_READ_OPERAND_OUT  out  `WORD_LEN  load data.
- DESTINATION_OUT  out  `REG_ADDR_LEN  DESTINATION_IN passthrough.
- STALL  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- MISALIGN  out  1  misaligned-access flag; see Optional Feature.

Behaviour:
- Clocking and reset:
  - One clock, CLK. RESET_N is asynchronous and active-low.
  - On reset: FSM=IDLE, counter=0, read-data register RD_Q=0, STALL=0, MISALIGN=0.
  - Passthrough outputs follow their inputs.
  - Memory contents are not reset.
- Addressing:
  - Word index = ALU_RESULT_IN[log2(DMEM_DEPTH)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo DMEM_DEPTH words.
- Access detection:
  - ACC = MEM_READ_EN_IN | MEM_WRITE_EN_IN.
  - If both are high, the access is treated as a store and the read operand is 0.
- FSM for ACCESS_LAT ≥ 1 (states IDLE, BUSY, DONE):
  - IDLE, ACC=0: STALL=0, stay in IDLE.
  - IDLE, ACC=1: STALL=1 combinationally in the same cycle; load counter with ACCESS_LAT-1; next state BUSY if ACCESS_LAT>1, else DONE.
  - BUSY: STALL=1, counter decrements. At counter==0, capture mem[idx] into RD_Q and go to DONE.
  - DONE: STALL=0, MEM_READ_OPERAND_OUT=RD_Q.
  - The store is written at the rising edge that leaves DONE (exactly one write per store).
  - DONE always goes to IDLE, so a back-to-back memory op re-enters through IDLE on the next cycle.
  - Total: ACCESS_LAT stall cycles plus 1 completion cycle per memory op.
  - Non-memory ops never stall and take 1 cycle.
- FSM for ACCESS_LAT = 0:
  - FSM stays in IDLE and STALL=0.
  - Read is combinational from mem[idx]; store is written at the rising edge.
- Read-operand value:
  - MEM_READ_OPERAND_OUT = 0 whenever the current op is not a completing load.
- Inputs during stall:
  - ALU_RESULT_IN, ST_VAL_IN and the controls are held stable by the frozen EX/MEM register.
  - No re-sampling of the address is needed.
- Reset mid-access:
  - Return to IDLE immediately and drop STALL.
  - A pending store is discarded (no write occurs).

Optional Feature:
- Macro: DMEM_ALIGN_CHK_EN.
- Defined: an access with ALU_RESULT_IN[1:0] != 0 is suppressed.
  - No stall, no write; MEM_READ_OPERAND_OUT=0; WB_EN_OUT=0.
  - MISALIGN=1 combinationally for that cycle; the FSM stays in IDLE.
- Undefined: ALU_RESULT_IN[1:0] are ignored and MISALIGN is tied to 0.

Test Plan:
- Reset, then store ST_VAL_IN=0xDEADBEEF to address 0x10 with ACCESS_LAT=2:
  - STALL high for 2 cycles, then low.
  - A later load from 0x10 returns 0xDEADBEEF in its DONE cycle with WB_EN_OUT=1.
- Non-memory op (WB_EN_IN=1, ALU_RESULT_IN=0x55, DESTINATION_IN=7):
  - No stall; outputs 0x55 and 7 in the same cycle.
- Back-to-back load then store with ACCESS_LAT=2:
  - Each op shows exactly 2 stall cycles plus 1 DONE cycle.
  - WB_EN_OUT is 0 during every stall cycle.
- Assert RESET_N low during BUSY of a store to 0x20:
  - STALL drops asynchronously.
  - A subsequent load from 0x20 returns the old contents.
- Address wrap with DMEM_DEPTH=1024:
  - Store 0x1234 to 0x1004, then load from 0x0004: returns 0x1234.
- With DMEM_ALIGN_CHK_EN defined, load from 0x13:
  - MISALIGN=1, STALL=0, WB_EN_OUT=0, MEM_READ_OPERAND_OUT=0.
